clock_ctrl: RTL and testbench
=============================

CLOCK_CTRL -- requirements
Module: clock_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of the burst cycle counter.
REQ-002 Parameter SEL_W, default 3, width of the divider select.
REQ-003 clk  in  1  system clock; all state changes occur on its rising edge.
REQ-004 arst  in  1  reset, synchronous, active-high.
REQ-005 run_req  in  1  one-cycle pulse: free-run request.
REQ-006 stop_req  in  1  one-cycle pulse: halt request.
REQ-007 step_req  in  1  one-cycle pulse: execute exactly one CPU cycle.
REQ-008 burst_req  in  1  one-cycle pulse: execute burst_len CPU cycles.
REQ-009 burst_len  in  CNT_W  burst cycle count, sampled with burst_req.
REQ-010 sel_wr  in  1  one-cycle pulse: write sel_in to the pending select register.
REQ-011 sel_in  in  SEL_W  requested divider tap.
REQ-012 cyc_end  in  1  one-cycle pulse from the CPU marking a completed CPU cycle.
REQ-013 bkpt_en  in  1  breakpoint enable, level.
REQ-014 bkpt_addr  in  16  breakpoint address.
REQ-015 cpu_addr  in  16  current CPU address, valid when cyc_end=1.
REQ-016 clk_sel  out  SEL_W  divider select driven to the clock generator.
REQ-017 stop_clk  out  1  freeze request driven to the clock generator.
REQ-018 mode  out  2  current FSM state encoding.
REQ-019 bkpt_hit  out  1  sticky flag: last halt was caused by the breakpoint.
REQ-020 cyc_left  out  CNT_W  remaining burst cycles.

Function
REQ-021 The FSM SHALL have states STOPPED=0, RUN=1, STEP=2, BURST=3; mode SHALL equal the state; stop_clk SHALL be 1 exactly when the state is STOPPED, registered.
REQ-022 In STOPPED: run_req->RUN; step_req->STEP; burst_req with burst_len!=0->BURST, loading cyc_left=burst_len; burst_req with burst_len=0->remain STOPPED with no flag change.
REQ-023 Simultaneous requests in STOPPED SHALL resolve by priority stop_req > run_req > step_req > burst_req; a stop_req in the same cycle SHALL cancel all others.
REQ-024 Leaving STOPPED SHALL clear bkpt_hit in the same edge; stop_clk SHALL deassert on the edge after the accepting request (1-cycle latency).
REQ-025 In RUN/STEP/BURST, run/step/burst requests SHALL be ignored; stop_req SHALL go to STOPPED on the next edge regardless of cyc_end.
REQ-026 STEP SHALL return to STOPPED on the first cyc_end.
REQ-027 BURST SHALL decrement cyc_left on each cyc_end; the cyc_end that takes cyc_left from 1 to 0 SHALL return to STOPPED.
REQ-028 Breakpoint: in RUN or BURST, cyc_end with bkpt_en=1 and cpu_addr==bkpt_addr SHALL go to STOPPED and set bkpt_hit; in BURST cyc_left SHALL still decrement on that cycle. STEP SHALL ignore the breakpoint.
REQ-029 When stop_req and a breakpoint match occur together, the next state SHALL be STOPPED and bkpt_hit SHALL be set.
REQ-030 sel_wr SHALL update the pending select register; a later sel_wr overwrites an earlier one.
REQ-031 Pending select SHALL transfer to clk_sel on any edge where the state is STOPPED or cyc_end=1, so the divider never changes mid CPU cycle.
REQ-032 cyc_end in STOPPED SHALL be ignored apart from REQ-031.

Reset
REQ-033 With arst=1 at a rising edge: state=STOPPED, stop_clk=1, clk_sel=0, pending select=0, bkpt_hit=0, cyc_left=0; all requests in that cycle are discarded.
REQ-034 Reset asserted mid-BURST SHALL abort the burst without completing the current CPU cycle.

Structure
REQ-035 State enum and encodings, CNT_W/SEL_W defaults SHALL live in the shared package clock_ctrl_pkg.
REQ-036 Breakpoint compare SHALL be a sub-module bkpt_match (combinational compare, enable-gated).

Verification
REQ-037 Reset, then step_req -> stop_clk 0 one cycle later; cyc_end -> stop_clk 1 next edge, mode=0.
REQ-038 burst_req, burst_len=3 -> cyc_left 3,2,1,0 on successive cyc_end; STOPPED after the third; burst_len=0 -> no state change.
REQ-039 RUN, bkpt_en=1, bkpt_addr=16'h0100, cyc_end with cpu_addr=16'h0100 -> STOPPED, bkpt_hit=1; next run_req clears bkpt_hit.
REQ-040 In RUN, sel_wr sel_in=5 -> clk_sel unchanged until the next cyc_end, then 5.
REQ-041 STOPPED, run_req+stop_req same cycle -> remains STOPPED; in BURST with cyc_left=2, arst -> cyc_left=0, stop_clk=1, clk_sel=0.
REQ-042 BURST cyc_left=5, breakpoint match -> STOPPED, cyc_left=4, bkpt_hit=1.

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clock_ctrl_pkg
//  Description : Shared definitions for the CPU clock controller: parameter
//                defaults, FSM state type and encodings, and small helpers.
//  Contents    : c_CNT_W_DEF   default burst counter width
//                c_SEL_W_DEF   default divider select width
//                c_ADDR_W      breakpoint / CPU address width
//                state_t       FSM state type (also the 'mode' output)
//                c_ST_*        FSM state encodings
//  Revision    : 1.0  initial release
// ============================================================================
package clock_ctrl_pkg;

    localparam int c_CNT_W_DEF = 16;
    localparam int c_SEL_W_DEF = 3;
    localparam int c_ADDR_W    = 16;

    // The encodings are visible on the 'mode' output, so they are part of
    // the external interface and must not be reordered.
    typedef logic [1:0] state_t;

    localparam logic [1:0] c_ST_STOPPED = 2'd0;
    localparam logic [1:0] c_ST_RUN     = 2'd1;
    localparam logic [1:0] c_ST_STEP    = 2'd2;
    localparam logic [1:0] c_ST_BURST   = 2'd3;

    // Single-step is deliberately exempt from breakpoints so a debugger can
    // step off the breakpoint address.
    function automatic logic bkpt_armed(input state_t s);
        return (s == c_ST_RUN) || (s == c_ST_BURST);
    endfunction

endpackage : clock_ctrl_pkg
`default_nettype wire

// File: rtl/clock_ctrl_bkpt_match.sv
`default_nettype none
// ============================================================================
//  Module      : bkpt_match
//  Description : Combinational breakpoint comparator, gated by an enable.
//  Ports       : en         in   qualifies the compare (enable and cycle end)
//                bkpt_addr  in   programmed breakpoint address
//                cpu_addr   in   current CPU address
//                match      out  en and addresses equal
//  Revision    : 1.0  initial release
// ============================================================================
module bkpt_match
    import clock_ctrl_pkg::*;
(
    input  logic                en,
    input  logic [c_ADDR_W-1:0] bkpt_addr,
    input  logic [c_ADDR_W-1:0] cpu_addr,
    output logic                match
);

    assign match = en && (cpu_addr == bkpt_addr);

endmodule : bkpt_match
`default_nettype wire

// File: rtl/clock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clock_ctrl
//  Description : Debug clock controller for a CPU. Sequences free-run,
//                single-step and counted-burst execution, halts on a
//                breakpoint, and retimes divider select changes so they only
//                take effect between CPU cycles.
//  Ports       : clk        in   system clock, rising edge
//                arst       in   synchronous active-high reset
//                run_req    in   pulse: free run
//                stop_req   in   pulse: halt (highest priority)
//                step_req   in   pulse: run one CPU cycle
//                burst_req  in   pulse: run burst_len CPU cycles
//                burst_len  in   burst length, sampled with burst_req
//                sel_wr     in   pulse: write sel_in to pending select
//                sel_in     in   requested divider tap
//                cyc_end    in   pulse: CPU cycle completed
//                bkpt_en    in   breakpoint enable (level)
//                bkpt_addr  in   breakpoint address
//                cpu_addr   in   CPU address, valid with cyc_end
//                clk_sel    out  divider select to the clock generator
//                stop_clk   out  freeze request to the clock generator
//                mode       out  current FSM state
//                bkpt_hit   out  last halt was caused by the breakpoint
//                cyc_left   out  remaining burst cycles
//  Revision    : 1.0  initial release
// ============================================================================
module clock_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int CNT_W = c_CNT_W_DEF,
    parameter int SEL_W = c_SEL_W_DEF
) (
    input  logic                clk,
    input  logic                arst,
    input  logic                run_req,
    input  logic                stop_req,
    input  logic                step_req,
    input  logic                burst_req,
    input  logic [CNT_W-1:0]    burst_len,
    input  logic                sel_wr,
    input  logic [SEL_W-1:0]    sel_in,
    input  logic                cyc_end,
    input  logic                bkpt_en,
    input  logic [c_ADDR_W-1:0] bkpt_addr,
    input  logic [c_ADDR_W-1:0] cpu_addr,
    output logic [SEL_W-1:0]    clk_sel,
    output logic                stop_clk,
    output logic [1:0]          mode,
    output logic                bkpt_hit,
    output logic [CNT_W-1:0]    cyc_left
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t             r_state;
    logic               r_stop_clk;
    logic               r_bkpt_hit;
    logic [CNT_W-1:0]   r_cyc_left;
    logic [SEL_W-1:0]   r_sel_pend;
    logic [SEL_W-1:0]   r_clk_sel;

    state_t             w_state_nxt;
    logic               w_bkpt_hit_nxt;
    logic [CNT_W-1:0]   w_cyc_left_nxt;
    logic               w_bp_match;
    logic               w_bp_halt;
    logic               w_last_cycle;

    // ------------------------------------------------------------------------
    // Breakpoint compare: only meaningful at the end of a CPU cycle, when
    // cpu_addr is valid.
    // ------------------------------------------------------------------------
    bkpt_match u_bkpt_match (
        .en        (bkpt_en && cyc_end),
        .bkpt_addr (bkpt_addr),
        .cpu_addr  (cpu_addr),
        .match     (w_bp_match)
    );

    assign w_bp_halt    = w_bp_match && bkpt_armed(r_state);
    assign w_last_cycle = (r_cyc_left == CNT_W'(1));

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_cyc_left_nxt = r_cyc_left;
        w_bkpt_hit_nxt = r_bkpt_hit;

        case (r_state)
            c_ST_STOPPED: begin
                // A concurrent stop_req cancels every other request.
                if (!stop_req) begin
                    if (run_req) begin
                        w_state_nxt = c_ST_RUN;
                    end else if (step_req) begin
                        w_state_nxt = c_ST_STEP;
                    end else if (burst_req && (burst_len != '0)) begin
                        w_state_nxt    = c_ST_BURST;
                        w_cyc_left_nxt = burst_len;
                    end
                end
            end

            c_ST_RUN: begin
                if (stop_req || w_bp_halt) begin
                    w_state_nxt = c_ST_STOPPED;
                end
            end

            c_ST_STEP: begin
                if (stop_req || cyc_end) begin
                    w_state_nxt = c_ST_STOPPED;
                end
            end

            c_ST_BURST: begin
                // The count tracks completed CPU cycles, so it still
                // decrements on a cycle that also hits the breakpoint.
                if (cyc_end) begin
                    w_cyc_left_nxt = r_cyc_left - CNT_W'(1);
                end
                if (stop_req || w_bp_halt || (cyc_end && w_last_cycle)) begin
                    w_state_nxt = c_ST_STOPPED;
                end
            end

            default: begin
                w_state_nxt = c_ST_STOPPED;
            end
        endcase

        // Any accepted start request begins a new session, forgetting the
        // reason for the previous halt.
        if ((r_state == c_ST_STOPPED) && (w_state_nxt != c_ST_STOPPED)) begin
            w_bkpt_hit_nxt = 1'b0;
        end
        // A breakpoint halt is recorded even when stop_req arrives together.
        if (w_bp_halt) begin
            w_bkpt_hit_nxt = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (arst) begin
            r_state    <= c_ST_STOPPED;
            r_stop_clk <= 1'b1;
            r_bkpt_hit <= 1'b0;
            r_cyc_left <= '0;
            r_sel_pend <= '0;
            r_clk_sel  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            // Registered from the next state so the freeze tracks mode
            // exactly without a combinational path to the clock generator.
            r_stop_clk <= (w_state_nxt == c_ST_STOPPED);
            r_bkpt_hit <= w_bkpt_hit_nxt;
            r_cyc_left <= w_cyc_left_nxt;

            // The divider may only retune while the CPU is frozen or at a
            // cycle boundary; the value transferred is the one pending
            // before this edge's sel_wr.
            if ((r_state == c_ST_STOPPED) || cyc_end) begin
                r_clk_sel <= r_sel_pend;
            end
            if (sel_wr) begin
                r_sel_pend <= sel_in;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign clk_sel  = r_clk_sel;
    assign stop_clk = r_stop_clk;
    assign mode     = r_state;
    assign bkpt_hit = r_bkpt_hit;
    assign cyc_left = r_cyc_left;

endmodule : clock_ctrl
`default_nettype wire

// File: tb/tb_clock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clock_ctrl
//  Description : Self-checking bench for clock_ctrl. Directed scenarios
//                followed by random request traffic, all compared against a
//                behavioural reference model of the controller.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_clock_ctrl;

    localparam int CNT_W = 16;
    localparam int SEL_W = 3;

    logic             clk = 1'b0;
    logic             arst = 1'b0;
    logic             run_req = 1'b0;
    logic             stop_req = 1'b0;
    logic             step_req = 1'b0;
    logic             burst_req = 1'b0;
    logic [CNT_W-1:0] burst_len = '0;
    logic             sel_wr = 1'b0;
    logic [SEL_W-1:0] sel_in = '0;
    logic             cyc_end = 1'b0;
    logic             bkpt_en = 1'b0;
    logic [15:0]      bkpt_addr = '0;
    logic [15:0]      cpu_addr = '0;
    logic [SEL_W-1:0] clk_sel;
    logic             stop_clk;
    logic [1:0]       mode;
    logic             bkpt_hit;
    logic [CNT_W-1:0] cyc_left;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode as a number (0 stopped, 1 run, 2 step, 3 burst),
    // plain integer counters for everything else.
    int m_mode = 0;
    int m_left = 0;
    int m_hit  = 0;
    int m_sel  = 0;
    int m_pend = 0;

    clock_ctrl #(.CNT_W(CNT_W), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .arst      (arst),
        .run_req   (run_req),
        .stop_req  (stop_req),
        .step_req  (step_req),
        .burst_req (burst_req),
        .burst_len (burst_len),
        .sel_wr    (sel_wr),
        .sel_in    (sel_in),
        .cyc_end   (cyc_end),
        .bkpt_en   (bkpt_en),
        .bkpt_addr (bkpt_addr),
        .cpu_addr  (cpu_addr),
        .clk_sel   (clk_sel),
        .stop_clk  (stop_clk),
        .mode      (mode),
        .bkpt_hit  (bkpt_hit),
        .cyc_left  (cyc_left)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        int  nxt;
        bit  bp;
        if (arst) begin
            m_mode = 0; m_left = 0; m_hit = 0; m_sel = 0; m_pend = 0;
            return;
        end
        bp = bkpt_en && cyc_end && (cpu_addr == bkpt_addr);
        if (m_mode == 0 || cyc_end) m_sel = m_pend;
        if (sel_wr) m_pend = int'(sel_in);
        nxt = m_mode;
        case (m_mode)
            0: begin
                if (stop_req)                        nxt = 0;
                else if (run_req)                    nxt = 1;
                else if (step_req)                   nxt = 2;
                else if (burst_req && burst_len > 0) begin
                    nxt    = 3;
                    m_left = int'(burst_len);
                end
                if (nxt != 0) m_hit = 0;
            end
            1: begin
                if (stop_req || bp) nxt = 0;
                if (bp) m_hit = 1;
            end
            2: begin
                if (stop_req || cyc_end) nxt = 0;
            end
            default: begin
                if (cyc_end) m_left = m_left - 1;
                if (stop_req || bp || (cyc_end && m_left == 0)) nxt = 0;
                if (bp) m_hit = 1;
            end
        endcase
        m_mode = nxt;
    endtask

    // One clock: update model, let the edge pass, compare every output,
    // then drop all pulse inputs.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("mode",     int'(mode),     m_mode);
        check("stop_clk", int'(stop_clk), (m_mode == 0) ? 1 : 0);
        check("clk_sel",  int'(clk_sel),  m_sel);
        check("bkpt_hit", int'(bkpt_hit), m_hit);
        check("cyc_left", int'(cyc_left), m_left);
        arst = 0; run_req = 0; stop_req = 0; step_req = 0; burst_req = 0;
        sel_wr = 0; cyc_end = 0;
    endtask

    initial begin
        // Reset, with a request that must be discarded.
        arst = 1; run_req = 1; tick();
        check("rst_stop_clk", int'(stop_clk), 1);
        check("rst_mode", int'(mode), 0);

        // Single step.
        step_req = 1; tick();
        check("step_run", int'(stop_clk), 0);
        tick();
        cyc_end = 1; tick();
        check("step_done_stop", int'(stop_clk), 1);
        check("step_done_mode", int'(mode), 0);

        // Burst of 3.
        burst_len = 16'd3; burst_req = 1; tick();
        check("burst_load", int'(cyc_left), 3);
        for (int i = 2; i >= 0; i--) begin
            tick();
            cyc_end = 1; tick();
            check("burst_count", int'(cyc_left), i);
        end
        check("burst_end_mode", int'(mode), 0);
        burst_len = 16'd0; burst_req = 1; tick();
        check("burst_zero_mode", int'(mode), 0);

        // Breakpoint in RUN, then restart clears the flag.
        bkpt_en = 1; bkpt_addr = 16'h0100;
        run_req = 1; tick();
        cpu_addr = 16'h0080; cyc_end = 1; tick();
        cpu_addr = 16'h0100; cyc_end = 1; tick();
        check("bp_halt_hit", int'(bkpt_hit), 1);
        run_req = 1; tick();
        check("bp_restart_clear", int'(bkpt_hit), 0);
        stop_req = 1; tick();
        bkpt_en = 0; cpu_addr = 16'h0000;

        // Divider select held until cycle boundary while running.
        run_req = 1; tick();
        sel_wr = 1; sel_in = 3'd5; tick();
        check("sel_hold", int'(clk_sel), 0);
        tick(); tick();
        check("sel_hold2", int'(clk_sel), 0);
        cyc_end = 1; tick();
        check("sel_apply", int'(clk_sel), 5);
        stop_req = 1; tick();

        // run+stop together stays stopped; reset aborts a burst.
        run_req = 1; stop_req = 1; tick();
        check("runstop_mode", int'(mode), 0);
        burst_len = 16'd4; burst_req = 1; tick();
        cyc_end = 1; tick();
        cyc_end = 1; tick();
        check("burst_mid", int'(cyc_left), 2);
        arst = 1; tick();
        check("abort_left", int'(cyc_left), 0);
        check("abort_clk_sel", int'(clk_sel), 0);

        // Breakpoint during a burst of 5.
        bkpt_en = 1; bkpt_addr = 16'h0100;
        burst_len = 16'd5; burst_req = 1; tick();
        cpu_addr = 16'h0100; cyc_end = 1; tick();
        check("burst_bp_left", int'(cyc_left), 4);
        check("burst_bp_hit", int'(bkpt_hit), 1);

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            arst      = ($urandom_range(0, 199) == 0);
            run_req   = ($urandom_range(0, 9) == 0);
            stop_req  = ($urandom_range(0, 14) == 0);
            step_req  = ($urandom_range(0, 9) == 0);
            burst_req = ($urandom_range(0, 7) == 0);
            burst_len = CNT_W'($urandom_range(0, 6));
            sel_wr    = ($urandom_range(0, 9) == 0);
            sel_in    = SEL_W'($urandom);
            cyc_end   = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 49) == 0) bkpt_en = ~bkpt_en;
            if ($urandom_range(0, 99) == 0) bkpt_addr = 16'($urandom_range(0, 3));
            cpu_addr  = 16'($urandom_range(0, 5));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_clock_ctrl
`default_nettype wire
